i2c_slave_fsm: RTL and testbench

I2C_SLAVE_FSM -- requirements
Module: i2c_slave_fsm

---
 rtl/i2c_pkg.sv | 15 +
 rtl/i2c_bus_sync.sv | 44 ++++
 rtl/i2c_slave_fsm.sv | 147 ++++++++++++++
 tb/tb_i2c_slave_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encoding and default target address.
package i2c_pkg;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX        = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX        = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

  localparam logic [6:0] I2C_DEF_SLAVE_ADDR = 7'h50;
endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus registered SCL edge and START/STOP condition flags.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);
  logic r_scl_s1, r_scl_s2, r_scl_h;
  logic r_sda_s1, r_sda_s2, r_sda_h;
  logic [1:0] r_warm;
  logic r_scl_rise, r_scl_fall, r_start, r_stop;
  logic w_armed;

  // History flops hold the reset value until real pin data reaches them; block flags until then.
  assign w_armed = (r_warm == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
      r_warm <= 2'd0;
      r_scl_rise <= 1'b0; r_scl_fall <= 1'b0; r_start <= 1'b0; r_stop <= 1'b0;
    end else begin
      r_scl_s1 <= i_scl; r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
      r_sda_s1 <= i_sda; r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
      if (!w_armed) r_warm <= r_warm + 2'd1;
      r_scl_rise <= w_armed &  r_scl_s2 & ~r_scl_h;
      r_scl_fall <= w_armed & ~r_scl_s2 &  r_scl_h;
      r_start    <= w_armed &  r_scl_s2 &  r_sda_h & ~r_sda_s2;
      r_stop     <= w_armed &  r_scl_s2 & ~r_sda_h &  r_sda_s2;
    end
  end

  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;
  assign o_sda      = r_sda_h;
endmodule

// File: rtl/i2c_slave_fsm.sv
// I2C target: address match, byte receive with ready-driven ACK/NACK, byte transmit.
module i2c_slave_fsm
  import i2c_pkg::*;
#(
  parameter int ADDR_LEN = 7,
  parameter int DATA_LEN = 8,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR = ADDR_LEN'(I2C_DEF_SLAVE_ADDR)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  input  logic                sda_in,
  output logic                sda_oe,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_ack,
  output logic                busy,
  output logic [2:0]          state_slave
);
  localparam int SR_W = (DATA_LEN > ADDR_LEN + 1) ? DATA_LEN : ADDR_LEN + 1;

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
  i2c_state_e r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [SR_W-1:0] r_sr, w_sr_nxt, w_sr_in, w_tx_load;
  logic [DATA_LEN-1:0] r_rx_data, w_rxd_nxt;
  logic r_sda_oe, w_oe_nxt, r_rx_valid, w_rxv_nxt, r_tx_ack, w_txack_nxt;
  logic r_rw, w_rw_nxt, r_rx_ok, w_rxok_nxt, r_busy, w_busy_nxt;
  logic w_addr_hit, w_last_addr, w_last_data;

  i2c_bus_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_scl      (scl),
    .i_sda      (sda_in),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda      (w_sda)
  );

  assign w_sr_in     = {r_sr[SR_W-2:0], w_sda};
  assign w_addr_hit  = (w_sr_in[ADDR_LEN:1] == SLAVE_ADDR);
  assign w_last_addr = (r_cnt == 4'(ADDR_LEN));
  assign w_last_data = (r_cnt == 4'(DATA_LEN - 1));
  // MSB goes straight to the pin on the latch edge; the register keeps the remaining bits MSB-aligned.
  assign w_tx_load   = SR_W'({tx_data[DATA_LEN-2:0], 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop)       w_state_nxt = ST_IDLE;
    else if (w_start) w_state_nxt = ST_ADDR;
    else begin
      case (r_state)
        ST_ADDR:     if (w_scl_rise && w_last_addr) w_state_nxt = w_addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (w_scl_fall && r_cnt == 4'd1) w_state_nxt = r_rw ? ST_TX : ST_RX;
        ST_RX:       if (w_scl_rise && w_last_data) w_state_nxt = ST_RX_ACK;
        ST_RX_ACK:   if (w_scl_fall && r_cnt == 4'd1) w_state_nxt = ST_RX;
        ST_TX:       if (w_scl_fall && w_last_data) w_state_nxt = ST_TX_ACK;
        ST_TX_ACK: begin
          if (w_scl_rise && w_sda)                 w_state_nxt = ST_WAIT_STOP;
          else if (w_scl_fall && r_cnt == 4'd1)    w_state_nxt = ST_TX;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt; w_sr_nxt = r_sr; w_oe_nxt = r_sda_oe; w_rxd_nxt = r_rx_data;
    w_rxv_nxt = 1'b0; w_txack_nxt = 1'b0; w_rw_nxt = r_rw; w_rxok_nxt = r_rx_ok; w_busy_nxt = r_busy;
    if (w_stop) begin
      w_oe_nxt = 1'b0; w_busy_nxt = 1'b0; w_cnt_nxt = 4'd0;
    end else if (w_start) begin
      w_oe_nxt = 1'b0; w_busy_nxt = 1'b1; w_cnt_nxt = 4'd0; w_sr_nxt = '0;
    end else begin
      case (r_state)
        ST_ADDR: if (w_scl_rise) begin
          w_sr_nxt = w_sr_in; w_cnt_nxt = r_cnt + 4'd1;
          if (w_last_addr) w_rw_nxt = w_sda;
        end
        ST_ADDR_ACK: if (w_scl_fall) begin
          if (r_cnt == 4'd0) begin
            w_oe_nxt = 1'b1; w_cnt_nxt = 4'd1;
          end else if (r_rw) begin
            w_sr_nxt = w_tx_load; w_txack_nxt = 1'b1; w_oe_nxt = ~tx_data[DATA_LEN-1];
          end else w_oe_nxt = 1'b0;
        end
        ST_RX: if (w_scl_rise) begin
          w_sr_nxt = w_sr_in; w_cnt_nxt = r_cnt + 4'd1;
          if (w_last_data) begin
            w_rxd_nxt = w_sr_in[DATA_LEN-1:0]; w_rxv_nxt = rx_ready; w_rxok_nxt = rx_ready;
          end
        end
        ST_RX_ACK: if (w_scl_fall) begin
          if (r_cnt == 4'd0) begin w_oe_nxt = r_rx_ok; w_cnt_nxt = 4'd1; end
          else w_oe_nxt = 1'b0;
        end
        ST_TX: if (w_scl_fall) begin
          if (w_last_data) w_oe_nxt = 1'b0;
          else begin
            w_oe_nxt = ~r_sr[DATA_LEN-1]; w_sr_nxt = r_sr << 1; w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        ST_TX_ACK: begin
          if (w_scl_rise && !w_sda) w_cnt_nxt = 4'd1;
          else if (w_scl_fall && r_cnt == 4'd1) begin
            w_sr_nxt = w_tx_load; w_txack_nxt = 1'b1; w_oe_nxt = ~tx_data[DATA_LEN-1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0; r_sr <= '0; r_sda_oe <= 1'b0; r_rx_data <= '0; r_rx_valid <= 1'b0;
      r_tx_ack <= 1'b0; r_rw <= 1'b0; r_rx_ok <= 1'b0; r_busy <= 1'b0;
    end else begin
      r_cnt      <= (w_state_nxt != r_state) ? 4'd0 : w_cnt_nxt;
      r_sr       <= w_sr_nxt;
      r_sda_oe   <= w_oe_nxt;
      r_rx_data  <= w_rxd_nxt;
      r_rx_valid <= w_rxv_nxt;
      r_tx_ack   <= w_txack_nxt;
      r_rw       <= w_rw_nxt;
      r_rx_ok    <= w_rxok_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign sda_oe      = r_sda_oe;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_ack      = r_tx_ack;
  assign busy        = r_busy;
  assign state_slave = r_state;
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Bench for i2c_slave_fsm: bit-banged master, rx scoreboard queue, directed plus random transactions.
module tb_i2c_slave_fsm;
  localparam int Q = 6;
  localparam logic [6:0] MY_ADDR = 7'h50;
  localparam int S_IDLE = 0, S_ADDR = 1, S_WAIT_STOP = 7;

  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_sda = 1'b1, rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic sda_oe, rx_valid, tx_ack, busy;
  logic [7:0] rx_data;
  logic [2:0] state_slave;
  wire sda_bus = m_sda & ~sda_oe;

  int total = 0, bad = 0, n_txack = 0;
  bit oe_seen = 1'b0;
  logic [7:0] exp_rx_q[$];

  i2c_slave_fsm dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
    .tx_ack(tx_ack), .busy(busy), .state_slave(state_slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every rx_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sda_oe) oe_seen = 1'b1;
      if (tx_ack) n_txack++;
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_unexpected: got %0h expected no rx_valid", rx_data);
        end else chk("rx_data", rx_data, exp_rx_q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wt(); repeat (Q) @(negedge clk); endtask
  task automatic start_c(); m_sda = 1; wt(); scl = 1; wt(); m_sda = 0; wt(); scl = 0; wt(); endtask
  task automatic stop_c(); m_sda = 0; wt(); scl = 1; wt(); m_sda = 1; wt(); wt(); endtask
  task automatic clk_bit(input logic b, output logic r);
    m_sda = b; wt(); scl = 1; wt(); r = sda_bus; wt(); scl = 0; wt();
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask
  task automatic rd_byte(input logic mnack, input logic [7:0] nxt, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin clk_bit(1'b1, r); b[i] = r; end
    tx_data = nxt;
    clk_bit(mnack, r);
  endtask

  initial begin
    logic a, r;
    logic [7:0] got, d;
    logic [6:0] addr;
    logic [7:0] txb[4];
    int n;
    bit hit, rw, rdy;

    repeat (3) @(negedge clk);
    chk("rst_state", state_slave, S_IDLE);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ack", tx_ack, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1; repeat (6) @(negedge clk);

    // write 0xA0 to 0x50
    exp_rx_q.push_back(8'hA0);
    start_c();
    chk("w_busy", busy, 1);
    chk("w_state_addr", state_slave, S_ADDR);
    wr_byte({MY_ADDR, 1'b0}, a); chk("w_addr_ack", a, 0);
    wr_byte(8'hA0, a);           chk("w_data_ack", a, 0);
    stop_c();
    chk("w_state_idle", state_slave, S_IDLE);
    chk("w_busy_off", busy, 0);

    // address mismatch
    oe_seen = 0;
    start_c();
    wr_byte({7'h51, 1'b0}, a); chk("mis_addr_nack", a, 1);
    chk("mis_state", state_slave, S_WAIT_STOP);
    wr_byte(8'h12, a);         chk("mis_data_nack", a, 1);
    chk("mis_state2", state_slave, S_WAIT_STOP);
    stop_c();
    chk("mis_idle", state_slave, S_IDLE);
    chk("mis_oe_never", oe_seen, 0);

    // read 0x3C, 0xC3
    n_txack = 0; tx_data = 8'h3C;
    start_c();
    wr_byte({MY_ADDR, 1'b1}, a); chk("r_addr_ack", a, 0);
    rd_byte(1'b0, 8'hC3, got);   chk("r_byte0", got, 8'h3C);
    rd_byte(1'b1, 8'h00, got);   chk("r_byte1", got, 8'hC3);
    chk("r_wait_stop", state_slave, S_WAIT_STOP);
    stop_c();
    chk("r_idle", state_slave, S_IDLE);
    chk("r_txack_cnt", n_txack, 2);

    // rx_ready low -> NACK, no rx_valid
    start_c();
    wr_byte({MY_ADDR, 1'b0}, a); chk("nr_addr_ack", a, 0);
    rx_ready = 0;
    wr_byte(8'h55, a);           chk("nr_data_nack", a, 1);
    stop_c(); rx_ready = 1;

    // repeated START after 4 data bits
    start_c();
    wr_byte({MY_ADDR, 1'b0}, a); chk("rs_addr_ack", a, 0);
    clk_bit(1, r); clk_bit(0, r); clk_bit(1, r); clk_bit(1, r);
    start_c();
    chk("rs_state_addr", state_slave, S_ADDR);
    n_txack = 0; tx_data = 8'h5A;
    wr_byte({MY_ADDR, 1'b1}, a); chk("rs_addr_ack2", a, 0);
    rd_byte(1'b1, 8'h00, got);   chk("rs_byte", got, 8'h5A);
    stop_c();
    chk("rs_txack_cnt", n_txack, 1);

    // reset during TX bit 3
    tx_data = 8'h00;
    start_c();
    wr_byte({MY_ADDR, 1'b1}, a); chk("rr_addr_ack", a, 0);
    clk_bit(1, r); clk_bit(1, r);
    m_sda = 1; wt(); scl = 1; wt();
    chk("rr_driving", sda_oe, 1);
    rst_n = 0; #1;
    chk("rr_oe_rel", sda_oe, 0);
    chk("rr_state", state_slave, S_IDLE);
    repeat (3) @(negedge clk); rst_n = 1; wt(); scl = 0; wt();
    oe_seen = 0;
    for (int i = 0; i < 6; i++) clk_bit(1, r);
    wr_byte({MY_ADDR, 1'b0}, a); chk("rr_ignored_nack", a, 1);
    chk("rr_still_idle", state_slave, S_IDLE);
    chk("rr_oe_never", oe_seen, 0);
    chk("rr_not_busy", busy, 0);
    exp_rx_q.push_back(8'h69);
    start_c();
    wr_byte({MY_ADDR, 1'b0}, a); chk("rr_recover_ack", a, 0);
    wr_byte(8'h69, a);           chk("rr_recover_data", a, 0);
    stop_c();

    // random transactions against a byte-level model
    for (int t = 0; t < 12; t++) begin
      hit = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 3);
      addr = 7'($urandom_range(0, 127));
      if (hit) addr = MY_ADDR; else if (addr == MY_ADDR) addr = 7'h51;
      for (int i = 0; i < 4; i++) txb[i] = 8'($urandom);
      n_txack = 0; tx_data = txb[0];
      start_c();
      wr_byte({addr, rw}, a); chk("rnd_addr_ack", a, hit ? 0 : 1);
      if (!rw) begin
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom); rdy = 1'($urandom_range(0, 1));
          rx_ready = rdy;
          if (hit && rdy) exp_rx_q.push_back(d);
          wr_byte(d, a); chk("rnd_data_ack", a, (hit && rdy) ? 0 : 1);
        end
      end else if (hit) begin
        for (int i = 0; i < n; i++) begin
          rd_byte(i == n - 1, txb[i+1], got);
          chk("rnd_rd_byte", got, txb[i]);
        end
      end
      stop_c();
      rx_ready = 1;
      chk("rnd_idle", state_slave, S_IDLE);
      chk("rnd_txack_cnt", n_txack, (hit && rw) ? n : 0);
    end

    repeat (4) @(negedge clk);
    chk("rx_queue_drained", exp_rx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
